// File: rtl/llpm_route_buffered.sv
// Destination router with one output buffer slot per channel.
// Optional LLPM_ROUTE_BUFFERED_OOR_DROP_EN: accept and count out-of-range tokens.
module llpm_route_buffered #(
  parameter int Width           = 8,
  parameter int NumOutputs      = 4,
  parameter int CLog2NumOutputs = 2
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [Width-1:0]           x,
  input  logic [CLog2NumOutputs-1:0] x_dest,
  input  logic                       x_valid,
  output logic                       x_bp,
  output logic [Width-1:0]           a       [NumOutputs-1:0],
  output logic                       a_valid [NumOutputs-1:0],
  input  logic                       a_bp    [NumOutputs-1:0]
`ifdef LLPM_ROUTE_BUFFERED_OOR_DROP_EN
  ,
  output logic [15:0]                drop_count
`endif
);

  logic [NumOutputs-1:0] full_q;
  logic [NumOutputs-1:0] full_d;
  logic [NumOutputs-1:0] free;
  logic [NumOutputs-1:0] ld;
  logic [Width-1:0]      data_q [NumOutputs-1:0];
  logic                  in_range;
  logic                  sel_free;
  logic                  accept;

  assign in_range = (32'(x_dest) < 32'(NumOutputs));

  // A slot is free when empty or being drained this cycle.
  always_comb begin
    free = '0;
    for (int k = 0; k < NumOutputs; k++) begin
      free[k] = ~full_q[k] | ~a_bp[k];
    end
  end

  assign sel_free = in_range & free[x_dest];

`ifdef LLPM_ROUTE_BUFFERED_OOR_DROP_EN
  logic        drop;
  logic [15:0] drop_count_q;
  logic [15:0] drop_count_d;

  assign accept = resetn & x_valid & (~in_range | sel_free);
  assign drop   = accept & ~in_range;

  // Saturating count of discarded out-of-range tokens.
  always_comb begin
    drop_count_d = drop_count_q;
    if (drop && drop_count_q != 16'hFFFF) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_count_q <= 16'd0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  assign accept = resetn & x_valid & sel_free;
`endif

  assign x_bp = ~accept;

  // Per-slot load enable and next full flag.
  always_comb begin
    ld     = '0;
    full_d = '0;
    for (int k = 0; k < NumOutputs; k++) begin
      ld[k]     = accept & in_range & (32'(x_dest) == 32'(k));
      full_d[k] = ld[k] | (full_q[k] & a_bp[k]);
    end
  end

  // Full flags clear asynchronously so outputs drop at once on reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q <= '0;
    end else begin
      full_q <= full_d;
    end
  end

  // Slot data needs no reset; it is qualified by the full flag.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NumOutputs; k++) begin
      if (ld[k]) begin
        data_q[k] <= x;
      end
    end
  end

  // Drive per-output ports from the slots.
  always_comb begin
    for (int k = 0; k < NumOutputs; k++) begin
      a[k]       = data_q[k];
      a_valid[k] = full_q[k];
    end
  end

endmodule

// File: tb/tb_llpm_route_buffered.sv
// Directed bench for llpm_route_buffered.
// Second instance (3 outputs) covers out-of-range destinations.
module tb_llpm_route_buffered;

  logic       clk;
  logic       resetn;

  logic [7:0] x;
  logic [1:0] x_dest;
  logic       x_valid;
  logic       x_bp;
  logic [7:0] a       [3:0];
  logic       a_valid [3:0];
  logic       a_bp    [3:0];
  logic [3:0] avp;

  logic [7:0] x1;
  logic [1:0] x1_dest;
  logic       x1_valid;
  logic       x1_bp;
  logic [7:0] a1       [2:0];
  logic       a1_valid [2:0];
  logic       a1_bp    [2:0];
  logic [2:0] avp1;
`ifdef LLPM_ROUTE_BUFFERED_OOR_DROP_EN
  logic [15:0] drop0;
  logic [15:0] drop1;
`endif

  int vecs;
  int errs;

  assign avp  = {a_valid[3], a_valid[2], a_valid[1], a_valid[0]};
  assign avp1 = {a1_valid[2], a1_valid[1], a1_valid[0]};

  llpm_route_buffered #(
    .Width(8), .NumOutputs(4), .CLog2NumOutputs(2)
  ) dut0 (
    .clk(clk), .resetn(resetn),
    .x(x), .x_dest(x_dest), .x_valid(x_valid), .x_bp(x_bp),
    .a(a), .a_valid(a_valid), .a_bp(a_bp)
`ifdef LLPM_ROUTE_BUFFERED_OOR_DROP_EN
    , .drop_count(drop0)
`endif
  );

  llpm_route_buffered #(
    .Width(8), .NumOutputs(3), .CLog2NumOutputs(2)
  ) dut1 (
    .clk(clk), .resetn(resetn),
    .x(x1), .x_dest(x1_dest), .x_valid(x1_valid), .x_bp(x1_bp),
    .a(a1), .a_valid(a1_valid), .a_bp(a1_bp)
`ifdef LLPM_ROUTE_BUFFERED_OOR_DROP_EN
    , .drop_count(drop1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    resetn = 1'b0;
    x = '0; x_dest = '0; x_valid = 1'b0;
    x1 = '0; x1_dest = '0; x1_valid = 1'b0;
    for (int k = 0; k < 4; k++) a_bp[k] = 1'b0;
    for (int k = 0; k < 3; k++) a1_bp[k] = 1'b0;

    // Reset state
    step();
    x_valid = 1'b1;
    #1;
    chk("rst_avalid", 32'(avp), 32'h0);
    chk("rst_xbp", 32'(x_bp), 32'h1);
    x_valid = 1'b0;
    step();
    resetn = 1'b1;

    // Basic route to dest 2
    x = 8'hA5; x_dest = 2'd2; x_valid = 1'b1;
    #1;
    chk("a5_xbp", 32'(x_bp), 32'h0);
    step();
    x_valid = 1'b0;
    chk("a5_data", 32'(a[2]), 32'hA5);
    chk("a5_avalid", 32'(avp), 32'h4);
    step();
    chk("a5_drain", 32'(avp), 32'h0);

    // Stall on dest 1
    a_bp[1] = 1'b1;
    x = 8'h11; x_dest = 2'd1; x_valid = 1'b1;
    #1;
    chk("s11_xbp", 32'(x_bp), 32'h0);
    step();
    chk("s11_data", 32'(a[1]), 32'h11);
    chk("s11_avalid", 32'(avp), 32'h2);
    x = 8'h22;
    #1;
    chk("s22_blocked", 32'(x_bp), 32'h1);
    step();
    chk("s11_stable", 32'(a[1]), 32'h11);
    chk("s11_stable_v", 32'(avp), 32'h2);
    a_bp[1] = 1'b0;
    #1;
    chk("s22_xbp", 32'(x_bp), 32'h0);
    step();
    x_valid = 1'b0;
    chk("s22_data", 32'(a[1]), 32'h22);
    chk("s22_avalid", 32'(avp), 32'h2);

    // Stalled output does not block another
    a_bp[0] = 1'b1;
    x = 8'h30; x_dest = 2'd0; x_valid = 1'b1;
    step();
    chk("s30_avalid", 32'(avp), 32'h1);
    x = 8'h33; x_dest = 2'd3;
    #1;
    chk("s33_xbp", 32'(x_bp), 32'h0);
    step();
    x_valid = 1'b0;
    chk("s33_data", 32'(a[3]), 32'h33);
    chk("s30_hold", 32'(a[0]), 32'h30);
    chk("s33_avalid", 32'(avp), 32'h9);
    step();
    chk("s33_drain", 32'(avp), 32'h1);
    a_bp[0] = 1'b0;
    step();
    chk("s30_drain", 32'(avp), 32'h0);

    // Back-to-back stream to dest 0
    x_dest = 2'd0;
    for (int i = 1; i <= 8; i++) begin
      x = 8'(i);
      x_valid = 1'b1;
      #1;
      chk("strm_xbp", 32'(x_bp), 32'h0);
      step();
      chk("strm_data", 32'(a[0]), 32'(i));
      chk("strm_avalid", 32'(avp), 32'h1);
    end
    x_valid = 1'b0;
    step();
    chk("strm_end", 32'(avp), 32'h0);

    // Mid-cycle reset discards slot 2
    a_bp[2] = 1'b1;
    x = 8'h55; x_dest = 2'd2; x_valid = 1'b1;
    step();
    x_valid = 1'b0;
    chk("r55_avalid", 32'(avp), 32'h4);
    #2;
    resetn = 1'b0;
    #1;
    chk("r_async_clr", 32'(avp), 32'h0);
    x_valid = 1'b1;
    #1;
    chk("r_xbp", 32'(x_bp), 32'h1);
    x_valid = 1'b0;
    step();
    resetn = 1'b1;
    a_bp[2] = 1'b0;
    x = 8'h44; x_dest = 2'd2; x_valid = 1'b1;
    #1;
    chk("r44_xbp", 32'(x_bp), 32'h0);
    step();
    x_valid = 1'b0;
    chk("r44_data", 32'(a[2]), 32'h44);
    chk("r44_avalid", 32'(avp), 32'h4);

    // Three-output instance: in-range then out-of-range
    x1 = 8'h66; x1_dest = 2'd2; x1_valid = 1'b1;
    #1;
    chk("n3_xbp", 32'(x1_bp), 32'h0);
    step();
    x1_valid = 1'b0;
    chk("n3_data", 32'(a1[2]), 32'h66);
    chk("n3_avalid", 32'(avp1), 32'h4);
    step();
    chk("n3_drain", 32'(avp1), 32'h0);
    x1 = 8'h77; x1_dest = 2'd3; x1_valid = 1'b1;
`ifdef LLPM_ROUTE_BUFFERED_OOR_DROP_EN
    #1;
    chk("oor_xbp", 32'(x1_bp), 32'h0);
    chk("oor_cnt0", 32'(drop1), 32'h0);
    step();
    x1_valid = 1'b0;
    chk("oor_cnt1", 32'(drop1), 32'h1);
    chk("oor_avalid", 32'(avp1), 32'h0);
    step();
    chk("oor_cnt_hold", 32'(drop1), 32'h1);
`else
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("oor_xbp", 32'(x1_bp), 32'h1);
      step();
      chk("oor_avalid", 32'(avp1), 32'h0);
    end
    x1_valid = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
